mimo_zf_eq_nxn: RTL

Parametrised successor to the fixed 2x2 ZF equalizer: computes X = Hinv[k]·Y[k] for an NANT x NANT complex system.
- Holds a separate Hinv matrix for each subcarrier k in an internal coefficient RAM, instead of one fixed matrix.
- Adds a subcarrier-indexed symbol FSM, rounding with saturation, and error flags.
- Sits between the FFT output and the demapper.

---
 rtl/mimo_zf_pkg.sv | 25 ++
 rtl/mimo_zf_cdot.sv | 82 ++++++++
 rtl/mimo_zf_eq_nxn.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mimo_zf_pkg.sv
// Shared constants and FSM encoding for the NxN zero-forcing equalizer.
// Saturation bounds are provided as functions so any DATA_W can reuse them.
package mimo_zf_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 14;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(DATA_W_DEF);
    localparam longint SAT_MIN = sat_min(DATA_W_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mimo_zf_cdot.sv
// One output row of X = Hinv * Y: registered complex products, then a
// rounded, saturated sum registered on ld. The sat output flags the value being loaded.
module mimo_zf_cdot
    import mimo_zf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int NANT   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld,
    input  logic [NANT*2*DATA_W-1:0] h_row,
    input  logic [NANT*2*DATA_W-1:0] y,
    output logic [2*DATA_W-1:0]      x,
    output logic                     sat
);
    localparam int PW    = 2 * DATA_W;
    localparam int SUM_W = PW + $clog2(NANT) + 1;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_max(DATA_W));
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_min(DATA_W));
    localparam logic signed [SUM_W-1:0] RND    = SUM_W'(1) <<< (FRAC_W - 1);

    logic signed [PW-1:0]    h_re [NANT];
    logic signed [PW-1:0]    h_im [NANT];
    logic signed [PW-1:0]    y_re [NANT];
    logic signed [PW-1:0]    y_im [NANT];
    logic signed [PW-1:0]    p_ac [NANT];
    logic signed [PW-1:0]    p_bd [NANT];
    logic signed [PW-1:0]    p_ad [NANT];
    logic signed [PW-1:0]    p_bc [NANT];
    logic signed [SUM_W-1:0] acc_re, acc_im, sh_re, sh_im;
    logic [DATA_W-1:0]       q_re, q_im;
    logic                    sat_re, sat_im;

    always_comb begin
        for (int j = 0; j < NANT; j++) begin
            h_re[j] = PW'($signed(h_row[(NANT-1-j)*PW + DATA_W +: DATA_W]));
            h_im[j] = PW'($signed(h_row[(NANT-1-j)*PW +: DATA_W]));
            y_re[j] = PW'($signed(y[(NANT-1-j)*PW + DATA_W +: DATA_W]));
            y_im[j] = PW'($signed(y[(NANT-1-j)*PW +: DATA_W]));
        end
    end

    // NOTE: datapath flops carry no reset; only valid/control state needs a known value.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NANT; j++) begin
            p_ac[j] <= h_re[j] * y_re[j];
            p_bd[j] <= h_im[j] * y_im[j];
            p_ad[j] <= h_re[j] * y_im[j];
            p_bc[j] <= h_im[j] * y_re[j];
        end
    end

    // NOTE: blocking assignments here on purpose: the accumulators chain within one evaluation.
    always_comb begin
        acc_re = RND;
        acc_im = RND;
        for (int j = 0; j < NANT; j++) begin
            acc_re = acc_re + SUM_W'(p_ac[j]) - SUM_W'(p_bd[j]);
            acc_im = acc_im + SUM_W'(p_ad[j]) + SUM_W'(p_bc[j]);
        end
        sh_re = acc_re >>> FRAC_W;
        sh_im = acc_im >>> FRAC_W;
    end

    function automatic logic [DATA_W:0] clip(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI) return {1'b1, SAT_HI[DATA_W-1:0]};
        if (v < SAT_LO) return {1'b1, SAT_LO[DATA_W-1:0]};
        return {1'b0, v[DATA_W-1:0]};
    endfunction

    assign {sat_re, q_re} = clip(sh_re);
    assign {sat_im, q_im} = clip(sh_im);
    assign sat = sat_re | sat_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  x <= '0;
        else if (ld) x <= {q_re, q_im};
    end

endmodule

// File: rtl/mimo_zf_eq_nxn.sv
// NxN zero-forcing equalizer, X = Hinv[k]*Y[k], with per-subcarrier coefficient RAM and 3-cycle pipe.
// Optional saturation event counter enabled by defining MIMO_ZF_SAT_CNT_EN.
module mimo_zf_eq_nxn
    import mimo_zf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int NANT   = 2,
    parameter int NFFT   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          h_wr_en,
    input  logic [$clog2(NFFT)-1:0]       h_wr_addr,
    input  logic [NANT*NANT*2*DATA_W-1:0] h_wr_data,
    input  logic                          in_valid,
    input  logic [NANT*2*DATA_W-1:0]      y_in,
    output logic                          out_valid,
    output logic [NANT*2*DATA_W-1:0]      x_out,
    output logic [$clog2(NFFT)-1:0]       out_sc_idx,
    output logic                          sym_done,
    output logic                          sat_flag,
    output logic                          h_wr_err,
    output logic [15:0]                   sat_cnt
);
    localparam int AW = $clog2(NFFT);
    localparam int VW = NANT * 2 * DATA_W;
    localparam int MW = NANT * VW;
    localparam logic [AW-1:0] K_LAST = AW'(NFFT - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, k1, k2;
    logic [1:0]      drain_cnt;
    logic            v1, v2;
    logic [VW-1:0]   y1;
    logic [MW-1:0]   h1;
    logic [MW-1:0]   ram [NFFT];
    logic [NANT-1:0] sat_vec;
    logic            sat_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_RUN;
            ST_RUN:   if (in_valid && cnt == K_LAST) state_nxt = ST_DRAIN;
            ST_DRAIN: if (in_valid)                state_nxt = ST_RUN;
                      else if (drain_cnt == 2'd2) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            drain_cnt <= '0;
            h_wr_err  <= 1'b0;
        end else begin
            if (in_valid) cnt <= cnt + AW'(1);
            drain_cnt <= (state == ST_DRAIN && state_nxt == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (h_wr_en && state != ST_IDLE) h_wr_err <= 1'b1;
        end
    end

    // NOTE: the coefficient RAM is never reset; a same-edge write to RAM[0] is read as old data.
    always_ff @(posedge clk) begin
        if (h_wr_en && state == ST_IDLE) ram[h_wr_addr] <= h_wr_data;
        h1 <= ram[cnt];
        y1 <= y_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            k1         <= '0;
            k2         <= '0;
            out_valid  <= 1'b0;
            out_sc_idx <= '0;
            sym_done   <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            v1        <= in_valid;
            k1        <= cnt;
            v2        <= v1;
            k2        <= k1;
            out_valid <= v2;
            sym_done  <= v2 && (k2 == K_LAST);
            if (v2) out_sc_idx <= k2;
            if (v2 && sat_any) sat_flag <= 1'b1;
        end
    end

    for (genvar r = 0; r < NANT; r++) begin : g_row
        mimo_zf_cdot #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .NANT   (NANT)
        ) u_cdot (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (v2),
            .h_row (h1[(NANT-1-r)*VW +: VW]),
            .y     (y1),
            .x     (x_out[(NANT-1-r)*2*DATA_W +: 2*DATA_W]),
            .sat   (sat_vec[r])
        );
    end

    assign sat_any = |sat_vec;

`ifdef MIMO_ZF_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       sat_cnt <= '0;
        else if (v2 && sat_any && sat_cnt != 16'hFFFF)   sat_cnt <= sat_cnt + 16'd1;
    end
`else
    assign sat_cnt = '0;
`endif

endmodule
